// File: rtl/sayac_mem_arbiter.sv
// Two-master round-robin arbiter for the single SAYAC memory port, with an access watchdog.
// Latency: strobe registered one edge after the request is seen; mi_ready one cycle after mem_ready.
// Backpressure: masters hold requests until mi_ready; requests are ignored outside IDLE.
module sayac_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  // Watchdog holds the number of cycles spent in ACCESS, including the current one.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              req0, req1;
  logic              win1;
  logic              ptr, ptr_nxt;  // 1: m1 wins the next contended arbitration
  logic [CNT_W-1:0]  wdog, wdog_nxt;
  logic [1:0]        grant_nxt;
  logic              mem_read_nxt, mem_write_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [DATA_W-1:0] m0_rdata_nxt, m1_rdata_nxt;
  logic              m0_ready_nxt, m1_ready_nxt;
  logic              timeout_nxt;
  logic [DATA_W-1:0] rsp_data;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // State, pointer, watchdog and every output are registered so reset clears them at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      wdog        <= '0;
      grant       <= 2'b00;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      wdog        <= wdog_nxt;
      grant       <= grant_nxt;
      mem_read    <= mem_read_nxt;
      mem_write   <= mem_write_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      m0_rdata    <= m0_rdata_nxt;
      m1_rdata    <= m1_rdata_nxt;
      m0_ready    <= m0_ready_nxt;
      m1_ready    <= m1_ready_nxt;
      timeout_err <= timeout_nxt;
    end
  end

  // Arbitration, access sequencing and watchdog; register inputs computed here.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    wdog_nxt      = wdog;
    grant_nxt     = grant;
    mem_read_nxt  = mem_read;
    mem_write_nxt = mem_write;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    m0_rdata_nxt  = m0_rdata;
    m1_rdata_nxt  = m1_rdata;
    m0_ready_nxt  = 1'b0;
    m1_ready_nxt  = 1'b0;
    timeout_nxt   = 1'b0;
    win1          = 1'b0;
    // Writes return zero data to the owner regardless of what the memory drives.
    rsp_data      = mem_read ? mem_rdata : '0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          win1 = req1 & (~req0 | ptr);
          // Only a contended grant moves the pointer: the loser gets the next contended
          // slot, so neither master is refused twice in a row.
          if (req0 && req1) begin
            ptr_nxt = ~win1;
          end
          grant_nxt = win1 ? 2'b10 : 2'b01;
          if (win1) begin
            mem_write_nxt = m1_write;
            mem_read_nxt  = m1_read & ~m1_write;
            mem_addr_nxt  = m1_addr;
            mem_wdata_nxt = m1_wdata;
          end else begin
            mem_write_nxt = m0_write;
            mem_read_nxt  = m0_read & ~m0_write;
            mem_addr_nxt  = m0_addr;
            mem_wdata_nxt = m0_wdata;
          end
          wdog_nxt  = CNT_W'(1);
          state_nxt = ACCESS;
        end
      end

      ACCESS: begin
        // Completion is checked first so a late ack on the last watchdog cycle still wins.
        if (mem_ready) begin
          if (grant[1]) begin
            m1_rdata_nxt = rsp_data;
            m1_ready_nxt = 1'b1;
          end else begin
            m0_rdata_nxt = rsp_data;
            m0_ready_nxt = 1'b1;
          end
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          state_nxt     = RESP;
        end else if ((TIMEOUT != 0) && (wdog == TO_VAL)) begin
          if (grant[1]) begin
            m1_rdata_nxt = '0;
            m1_ready_nxt = 1'b1;
          end else begin
            m0_rdata_nxt = '0;
            m0_ready_nxt = 1'b1;
          end
          timeout_nxt   = 1'b1;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          state_nxt     = RESP;
        end else if ((TIMEOUT != 0) && (wdog != TO_VAL)) begin
          wdog_nxt = wdog + CNT_W'(1);
        end
      end

      RESP: begin
        grant_nxt = 2'b00;
        wdog_nxt  = '0;
        state_nxt = IDLE;
      end

      default: begin
        grant_nxt     = 2'b00;
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        wdog_nxt      = '0;
        state_nxt     = IDLE;
      end
    endcase
  end

endmodule
